// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from host to a PS/2 device over open-drain clock/data lines
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a transfer that never reaches ACK.
// Ports: clk, rst (async, active-low); ps2Clk/ps2Data pin read-back; ps2ClkOe/ps2DataOe pull-low enables;
//        txData/txValid/txReady byte handshake; done pulse with err (no ACK or timeout).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES = 250,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       ps2ClkOe,
  output logic       ps2DataOe,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE, FIN} state_t;
  localparam int CW = $clog2(INHIBIT_CYCLES > SETUP_CYCLES ? INHIBIT_CYCLES : SETUP_CYCLES);
  localparam logic [CW-1:0] I_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYCLES - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] bcnt;
  logic [7:0] sh;
  logic par, doe, ack_ok;
  logic c_m, c_s, c_p, d_m, d_s, fall, tmo;
  // lines idle high, so synchronizers reset to 1 to avoid a spurious edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) {c_m, c_s, c_p, d_m, d_s} <= '1;
    else {c_m, c_s, c_p, d_m, d_s} <= {ps2Clk, c_m, c_s, ps2Data, d_m};
  assign fall = c_p & ~c_s;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  logic [WW-1:0] wd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) wd <= '0;
    else wd <= (state == SEND || state == ACK) ? wd + 1'b1 : '0;
  assign tmo = (state == SEND || state == ACK) && wd == WW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = txValid ? INHIBIT : IDLE;
      INHIBIT:   nxt = cnt == I_LAST ? START : INHIBIT;
      START:     nxt = cnt == S_LAST ? SEND : START;
      SEND:      nxt = fall && bcnt == 4'd9 ? ACK : SEND;
      ACK:       nxt = fall ? WAIT_IDLE : ACK;
      WAIT_IDLE: nxt = c_s && d_s ? FIN : WAIT_IDLE;
      default:   nxt = IDLE;
    endcase
    if (tmo) nxt = FIN;
  end
  // doe holds the start bit from acceptance; each edge in SEND loads the next frame bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      bcnt <= '0;
      sh <= '0;
      par <= 1'b0;
      doe <= 1'b0;
      ack_ok <= 1'b0;
    end else begin
      cnt <= (state == INHIBIT || state == START) && state == nxt ? cnt + 1'b1 : '0;
      if (state == IDLE && txValid) begin
        sh <= txData;
        par <= ~^txData;
        doe <= 1'b1;
        bcnt <= '0;
        ack_ok <= 1'b0;
      end
      if (state == SEND && fall) begin
        bcnt <= bcnt + 1'b1;
        doe <= bcnt < 4'd8 ? ~sh[bcnt[2:0]] : bcnt == 4'd8 ? ~par : 1'b0;
      end
      if (state == ACK && fall && !tmo) ack_ok <= ~d_s;
    end
  always_comb begin
    txReady = state == IDLE;
    ps2ClkOe = state == INHIBIT || state == START;
    ps2DataOe = (state == START || state == SEND) && doe;
    done = state == FIN;
    err = state == FIN && !ack_ok;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int SET = 5;
  localparam int TMO = 2000;
  logic clk = 0, rst = 0, txValid = 0, dclk = 0, ddat = 0;
  logic [7:0] txData = 0;
  logic ps2Clk, ps2Data, ps2ClkOe, ps2DataOe, txReady, done, err;
  int errs = 0, checks = 0;
  logic [10:0] fq[$];
  bit eq[$];
  bit done_prev = 0;
  int hi = 0, drise = -1;
  assign ps2Clk = ~(ps2ClkOe | dclk);
  assign ps2Data = ~(ps2DataOe | ddat);
  always #10 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2Clk(ps2Clk), .ps2Data(ps2Data), .ps2ClkOe(ps2ClkOe),
    .ps2DataOe(ps2DataOe), .txData(txData), .txValid(txValid), .txReady(txReady),
    .done(done), .err(err));
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction
  function automatic void bad(string n);
    checks++;
    errs++;
    $display("FAIL %s: got no event expected one within bound", n);
  endfunction
  // device-side view of a correct frame: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_of(logic [7:0] b);
    return {1'b1, ($countones(b) % 2 == 0), b, 1'b0};
  endfunction
  always @(negedge clk)
    if (!rst) done_prev = 0;
    else begin
      if (done_prev) begin
        chk("done_width", done, 0);
        chk("ready_after_done", txReady, 1);
      end
      if (done) begin
        chk("ready_in_done", txReady, 0);
        if (eq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else chk("err", err, eq.pop_front());
      end
      done_prev = done;
    end
  always @(negedge clk)
    if (!rst) begin
      hi = 0;
      drise = -1;
    end else if (ps2ClkOe) begin
      if (ps2DataOe && drise < 0) drise = hi;
      hi++;
    end else if (hi > 0) begin
      chk("clk_oe_cycles", hi, INH + SET);
      chk("data_oe_rise", drise, INH);
      hi = 0;
      drise = -1;
    end
  task automatic dev(input bit ack, input bit abort);
    int h, n;
    logic [10:0] f;
    h = $urandom_range(6, 12);
    n = 0;
    while (ps2ClkOe && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ps2ClkOe) begin
      bad("rts_timeout");
      return;
    end
    repeat (h) @(negedge clk);
    f[0] = ps2Data;
    for (int i = 1; i <= 10; i++) begin
      dclk = 1;
      repeat (h) @(negedge clk);
      if (abort && i == 4) return;
      dclk = 0;
      repeat (2) @(negedge clk);
      f[i] = ps2Data;
      repeat (h - 2) @(negedge clk);
    end
    if (ack) ddat = 1;
    repeat (2) @(negedge clk);
    dclk = 1;
    repeat (h) @(negedge clk);
    dclk = 0;
    repeat (2) @(negedge clk);
    ddat = 0;
    if (fq.size() == 0) bad("frame_expected");
    else chk("frame", f, fq.pop_front());
  endtask
  task automatic offer(input logic [7:0] b);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    txData = b;
    txValid = 1;
    while (!acc && n < 200) begin
      acc = txReady;
      @(posedge clk);
      #1;
      n++;
    end
    txValid = 0;
    txData = 8'($urandom);
    if (!acc) bad("accept_timeout");
    else chk("accept_latency", ps2ClkOe, 1);
  endtask
  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!done) bad("done_timeout");
  endtask
  task automatic send(input logic [7:0] b, input bit ack, input bit inj);
    fq.push_back(frame_of(b));
    eq.push_back(!ack);
    offer(b);
    fork
      dev(ack, 0);
      if (inj)
        for (int k = 0; k < 2; k++) begin
          repeat (k ? 50 : 8) @(negedge clk);
          txData = 8'h55;
          txValid = 1;
          @(negedge clk);
          txValid = 0;
        end
    join
    wait_done(400);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal;
  end
  initial begin
    int n;
    txValid = 1;
    txData = 8'hED;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2ClkOe, 0);
    chk("rst_data_oe", ps2DataOe, 0);
    chk("rst_ready", txReady, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    fq.push_back(frame_of(8'hED));
    eq.push_back(0);
    rst = 1;
    @(posedge clk);
    #1;
    txValid = 0;
    chk("accept_after_reset", ps2ClkOe, 1);
    chk("ready_busy", txReady, 0);
    dev(1, 0);
    wait_done(400);
    send(8'h01, 0, 0);
    send(8'h00, 1, 0);
    send(8'hF4, 1, 1);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'($urandom_range(0, 1)), 0);
`ifdef PS2_TX_TIMEOUT_EN
    eq.push_back(1);
    offer(8'hA5);
    n = 0;
    while (ps2ClkOe && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_clk_oe", ps2ClkOe, 0);
    chk("timeout_data_oe", ps2DataOe, 0);
    @(negedge clk);
`else
    offer(8'hA5);
    n = 0;
    repeat (10000) begin
      @(negedge clk);
      if (!txReady) n++;
    end
    chk("hang_ready_low", n, 10000);
    rst = 0;
    @(negedge clk);
    chk("hang_rst_ready", txReady, 1);
    rst = 1;
    @(negedge clk);
`endif
    offer(8'hF0);
    dev(1, 1);
    chk("pre_abort_data_oe", ps2DataOe, 1);
    rst = 0;
    #1;
    chk("abort_clk_oe", ps2ClkOe, 0);
    chk("abort_data_oe", ps2DataOe, 0);
    chk("abort_ready", txReady, 1);
    dclk = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (100) @(negedge clk);
    send(8'hFF, 1, 0);
    repeat (5) @(negedge clk);
    chk("eq_empty", eq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
